uart_tx_frame: RTL and testbench

Parametrised UART transmitter that generalises the fixed 8N1 serialiser in this codebase.
- Frame format is configurable: data width, parity (none/odd/even) and stop-bit count.
- Baud divisor is a runtime input, sampled once per frame.
- A one-entry holding register with a valid/ready handshake allows back-to-back frames with no idle gap.
- Sits between the console-mux byte source and the physical TX pin; output is line-idle-high.

---
 rtl/uart_tx_frame.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// UART transmitter with configurable data width, parity and stop bits; runtime baud divisor.
// Latency: a byte accepted on edge N drives the start bit from edge N+1; serial is registered.
// Backpressure: data_ready drops while the one-entry holding register is full; frames chain with no idle gap.
module uart_tx_frame #(
  parameter int DATA_BIT_COUNT = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BIT_COUNT = 1,
  parameter int DIV_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_BIT_COUNT-1:0] data,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic [DIV_WIDTH-1:0]      clk_per_bit,
  output logic                      tx_done,
  output logic                      busy,
  output logic                      serial
);

  // Bit counter covers both the data bit index and the stop bit index.
  localparam int BW = $clog2(DATA_BIT_COUNT + 1);

  if (DATA_BIT_COUNT < 5 || DATA_BIT_COUNT > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BIT_COUNT must be in 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BIT_COUNT < 1 || STOP_BIT_COUNT > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BIT_COUNT must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_BIT_COUNT-1:0] hold_q, hold_d;
  logic                      hold_full_q, hold_full_d;
  logic [DATA_BIT_COUNT-1:0] shift_q, shift_d;
  logic                      par_q, par_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  logic [DIV_WIDTH-1:0]      cyc_q, cyc_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic                      serial_q, serial_d;
  logic                      tx_done_q, tx_done_d;

  logic                      stop_end;
  logic                      load;
  logic [DIV_WIDTH:0]        cyc_inc;
  logic                      cyc_last;

  // Zero-extended so the last-cycle compare cannot wrap when D is all ones.
  assign cyc_inc  = {1'b0, cyc_q} + {{DIV_WIDTH{1'b0}}, 1'b1};
  assign cyc_last = (cyc_inc == {1'b0, div_q});

  assign data_ready = !hold_full_q;
  assign busy       = (state_q != S_IDLE) || hold_full_q;
  assign serial     = serial_q;
  assign tx_done    = tx_done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: holding register, shifter, divisor, counters, registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      div_q       <= {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      cyc_q       <= '0;
      bit_q       <= '0;
      serial_q    <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      div_q       <= div_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      serial_q    <= serial_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // Next-state and datapath update: bit timing, shifting and holding-register handoff.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    div_d       = div_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    stop_end    = 1'b0;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        load  = hold_full_q;
      end
      S_START: begin
        if (cyc_last) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_inc[DIV_WIDTH-1:0];
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BIT_COUNT - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_inc[DIV_WIDTH-1:0];
        end
      end
      S_PARITY: begin
        if (cyc_last) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          cyc_d = cyc_inc[DIV_WIDTH-1:0];
        end
      end
      S_STOP: begin
        if (cyc_last) begin
          cyc_d = '0;
          if (bit_q == BW'(STOP_BIT_COUNT - 1)) begin
            bit_d    = '0;
            stop_end = 1'b1;
            // A waiting byte starts its start bit right after this stop bit.
            load     = hold_full_q;
            state_d  = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_inc[DIV_WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase

    if (load) begin
      shift_d     = hold_q;
      par_d       = (PARITY_MODE == 1) ? ~(^hold_q) : (^hold_q);
      div_d       = (clk_per_bit == '0) ? {{(DIV_WIDTH-1){1'b0}}, 1'b1} : clk_per_bit;
      hold_full_d = 1'b0;
      cyc_d       = '0;
      bit_d       = '0;
      state_d     = S_START;
    end

    // Cannot coincide with a load: a load needs a full register, which holds data_ready low.
    if (data_valid && !hold_full_q) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end
  end

  // Output decode from the next state so the registered line lines up with state_q.
  always_comb begin
    tx_done_d = stop_end;
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_d;
      default:  serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
// Bench for uart_tx_frame: four instances cover 8N1, 8E1, 8O1 and 7O2.
// Expected line levels are queued per cycle as bytes are sent and compared while the frame plays out.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  din [4];
  logic [3:0]  dvld = 4'b0000;
  logic [15:0] cpb [4];
  wire  [3:0]  dready, txdone, busy, ser;

  int checks = 0;
  int errors = 0;

  // Each entry: {serial, tx_done, busy} expected for one clock cycle.
  logic [2:0] exp_q [$];
  logic       pend_done = 1'b0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BIT_COUNT(8), .PARITY_MODE(0), .STOP_BIT_COUNT(1), .DIV_WIDTH(16)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .data(din[0][7:0]), .data_valid(dvld[0]), .data_ready(dready[0]),
    .clk_per_bit(cpb[0]), .tx_done(txdone[0]), .busy(busy[0]), .serial(ser[0]));
  uart_tx_frame #(.DATA_BIT_COUNT(8), .PARITY_MODE(2), .STOP_BIT_COUNT(1), .DIV_WIDTH(16)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .data(din[1][7:0]), .data_valid(dvld[1]), .data_ready(dready[1]),
    .clk_per_bit(cpb[1]), .tx_done(txdone[1]), .busy(busy[1]), .serial(ser[1]));
  uart_tx_frame #(.DATA_BIT_COUNT(8), .PARITY_MODE(1), .STOP_BIT_COUNT(1), .DIV_WIDTH(16)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .data(din[2][7:0]), .data_valid(dvld[2]), .data_ready(dready[2]),
    .clk_per_bit(cpb[2]), .tx_done(txdone[2]), .busy(busy[2]), .serial(ser[2]));
  uart_tx_frame #(.DATA_BIT_COUNT(7), .PARITY_MODE(1), .STOP_BIT_COUNT(2), .DIV_WIDTH(16)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .data(din[3][6:0]), .data_valid(dvld[3]), .data_ready(dready[3]),
    .clk_per_bit(cpb[3]), .tx_done(txdone[3]), .busy(busy[3]), .serial(ser[3]));

  task automatic push_cyc(input logic s, input logic b);
    exp_q.push_back({s, pend_done, b});
    pend_done = 1'b0;
  endtask

  // Model of one frame; tx_done is expected on the cycle after the last stop cycle.
  task automatic push_frame(input logic [8:0] b, input int dbc, input int pm, input int sbc, input int d);
    logic p;
    p = 1'b0;
    for (int i = 0; i < d; i++) push_cyc(1'b0, 1'b1);
    for (int n = 0; n < dbc; n++) begin
      p = p ^ b[n];
      for (int i = 0; i < d; i++) push_cyc(b[n], 1'b1);
    end
    if (pm != 0) begin
      if (pm == 1) p = ~p;
      for (int i = 0; i < d; i++) push_cyc(p, 1'b1);
    end
    for (int i = 0; i < sbc * d; i++) push_cyc(1'b1, 1'b1);
    pend_done = 1'b1;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_cyc(1'b1, 1'b0);
  endtask

  // Waits for the start bit, then compares one queued entry per cycle. Called at a negedge.
  task automatic check_stream(input int k);
    int n;
    logic [2:0] e;
    n = 0;
    while (ser[k] !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL stream_start k=%0d: serial never went low, expected a start bit", k);
      exp_q.delete();
    end else begin
      n = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({ser[k], txdone[k], busy[k]} !== e) begin
          errors++;
          $display("FAIL stream k=%0d cyc=%0d: {serial,tx_done,busy} got %b expected %b",
                   k, n, {ser[k], txdone[k], busy[k]}, e);
        end
        n++;
        @(negedge clk);
      end
    end
  endtask

  // Presents a byte at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int k, input logic [8:0] b, output int waits);
    din[k]  = b;
    dvld[k] = 1'b1;
    waits   = 0;
    while (dready[k] !== 1'b1 && waits < 500) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 500) begin
      checks++;
      errors++;
      $display("FAIL send_timeout k=%0d: data_ready stayed %b, expected 1", k, dready[k]);
    end
    @(negedge clk);
    dvld[k] = 1'b0;
  endtask

  task automatic run_one(input int k, input logic [8:0] b, input int dbc, input int pm,
                         input int sbc, input int cpbv);
    int w;
    cpb[k] = 16'(cpbv);
    push_frame(b, dbc, pm, sbc, (cpbv == 0) ? 1 : cpbv);
    push_idle(4);
    fork
      check_stream(k);
      send(k, b, w);
    join
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ser[k], txdone[k], busy[k], dready[k]} !== 4'b1001) begin
        errors++;
        $display("FAIL %s k=%0d: {serial,tx_done,busy,data_ready} got %b expected 1001",
                 tag, k, {ser[k], txdone[k], busy[k], dready[k]});
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      din[k] = '0;
      cpb[k] = 16'd4;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
  endtask

  task automatic test_8n1();
    cpb[0] = 16'd4;
    push_frame(9'h055, 8, 0, 1, 4);
    push_idle(4);
    fork
      check_stream(0);
      begin
        din[0]  = 9'h055;
        dvld[0] = 1'b1;
        @(negedge clk);
        dvld[0] = 1'b0;
        checks++;
        if ({ser[0], dready[0], busy[0]} !== 3'b101) begin
          errors++;
          $display("FAIL latency_accept: {serial,data_ready,busy} got %b expected 101",
                   {ser[0], dready[0], busy[0]});
        end
        @(negedge clk);
        checks++;
        if (ser[0] !== 1'b0) begin
          errors++;
          $display("FAIL latency_start: serial got %b expected 0", ser[0]);
        end
      end
    join
  endtask

  task automatic test_parity();
    run_one(1, 9'h0A5, 8, 2, 1, 4);
    run_one(2, 9'h0A5, 8, 1, 1, 4);
    run_one(1, 9'h001, 8, 2, 1, 4);
    run_one(2, 9'h0C0, 8, 1, 1, 3);
  endtask

  task automatic test_back_to_back();
    int w1, w2, cnt;
    cpb[0] = 16'd4;
    push_frame(9'h000, 8, 0, 1, 4);
    push_frame(9'h0FF, 8, 0, 1, 4);
    push_idle(4);
    fork
      check_stream(0);
      begin
        send(0, 9'h000, w1);
        send(0, 9'h0FF, w2);
        checks++;
        if (w1 !== 0 || w2 !== 1) begin
          errors++;
          $display("FAIL b2b_accept: ready waits got %0d,%0d expected 0,1", w1, w2);
        end
        cnt = 0;
        while (dready[0] !== 1'b1 && cnt < 200) begin
          @(negedge clk);
          cnt++;
        end
        checks++;
        if (cnt !== 39) begin
          errors++;
          $display("FAIL b2b_ready_low: data_ready low for %0d cycles expected 39", cnt);
        end
      end
    join
  endtask

  task automatic test_divisor();
    int w;
    cpb[0] = 16'd4;
    push_frame(9'h03C, 8, 0, 1, 4);
    push_frame(9'h0C3, 8, 0, 1, 8);
    push_idle(4);
    fork
      check_stream(0);
      begin
        send(0, 9'h03C, w);
        send(0, 9'h0C3, w);
        repeat (8) @(negedge clk);
        cpb[0] = 16'd8;
      end
    join
    run_one(0, 9'h0A6, 8, 0, 1, 0);
  endtask

  task automatic test_7o2();
    run_one(3, 9'h07F, 7, 1, 2, 4);
    run_one(3, 9'h02A, 7, 1, 2, 2);
  endtask

  task automatic test_reset_midframe();
    int w, bad;
    cpb[0] = 16'd4;
    send(0, 9'h012, w);
    send(0, 9'h034, w);
    repeat (10) @(negedge clk);
    checks++;
    if ({busy[0], dready[0]} !== 2'b10) begin
      errors++;
      $display("FAIL midframe_busy: {busy,data_ready} got %b expected 10", {busy[0], dready[0]});
    end
    rst_n   = 1'b0;
    din[0]  = 9'h1FF;
    dvld[0] = 1'b1;
    @(negedge clk);
    dvld[0] = 1'b0;
    check_idle("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ser[0] !== 1'b1 || txdone[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midframe_quiet: %0d cycles with activity after reset, expected 0", bad);
    end
    run_one(0, 9'h096, 8, 0, 1, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_divisor();
    test_7o2();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
